// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and add/subtract mode constants.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result bus between a digit-serial add/subtract unit and its driver.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
);

  logic             start;
  logic             sub;
  logic             in_valid;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, in_valid, a_dig, b_dig,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, in_valid, a_dig, b_dig,
    output busy, done, sum, carry_out, overflow
  );

endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder; also reports the carry into the digit MSB for overflow.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  localparam int unsigned SW = DIGIT + 1;

  logic [DIGIT:0] full;

  always_comb begin
    full = SW'(a) + SW'(b) + SW'(cin);
  end

  assign s        = full[DIGIT-1:0];
  assign cout     = full[DIGIT];
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign c_msb_in = s[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: LSB-digit first, carry FF between beats, registered flags.
module serial_addsub
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  localparam int unsigned BEATS = WIDTH / DIGIT;
  localparam int unsigned CW    = $clog2(BEATS) + 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    count;
  logic             carry_q;
  logic             mode_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_c_msb;
  logic [WIDTH-1:0] sum_shift;
  logic             last_beat;

  // Subtraction is A + ~B + 1, the +1 entering through the carry FF at start.
  assign b_eff     = (mode_q == MODE_SUB) ? ~bus.b_dig : bus.b_dig;
  assign last_beat = (count == CW'(BEATS - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a        (bus.a_dig),
    .b        (b_eff),
    .cin      (carry_q),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_c_msb)
  );

  // New digit enters at the top; after the final beat the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_single
    assign sum_shift = dig_s;
  end else begin : g_shift
    assign sum_shift = {dig_s, sum_q[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= MODE_ADD;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q  <= bus.sub;
            carry_q <= bus.sub;
            count   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.in_valid) begin
            sum_q   <= sum_shift;
            carry_q <= dig_cout;
            count   <= count + CW'(1);
            if (last_beat) begin
              carry_out_q <= dig_cout;
              overflow_q  <= dig_c_msb ^ dig_cout;
              done_q      <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at DIGIT = 1, 4 and 8 with an 8-bit width.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] sum;
    logic       c;
    logic       v;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  serial_addsub_if #(.WIDTH(8), .DIGIT(1)) b1 ();
  serial_addsub_if #(.WIDTH(8), .DIGIT(4)) b4 ();
  serial_addsub_if #(.WIDTH(8), .DIGIT(8)) b8 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(b1));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(b4));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(b8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sb);
    exp_t       e;
    logic [8:0] r;
    if (!sb) begin
      r   = {1'b0, a} + {1'b0, b};
      e.c = r[8];
      e.v = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r   = {1'b0, a} - {1'b0, b};
      e.c = (a >= b);
      e.v = (a[7] != b[7]) && (r[7] != a[7]);
    end
    e.sum = r[7:0];
    e.cyc = 0;
    return e;
  endfunction

  task automatic drive(input int inst, input logic st, input logic sb, input logic vl,
                       input logic [7:0] ad, input logic [7:0] bd);
    b1.start = 1'b0; b1.sub = 1'b0; b1.in_valid = 1'b0; b1.a_dig = '0; b1.b_dig = '0;
    b4.start = 1'b0; b4.sub = 1'b0; b4.in_valid = 1'b0; b4.a_dig = '0; b4.b_dig = '0;
    b8.start = 1'b0; b8.sub = 1'b0; b8.in_valid = 1'b0; b8.a_dig = '0; b8.b_dig = '0;
    case (inst)
      1: begin b1.start = st; b1.sub = sb; b1.in_valid = vl; b1.a_dig = ad[0:0]; b1.b_dig = bd[0:0]; end
      4: begin b4.start = st; b4.sub = sb; b4.in_valid = vl; b4.a_dig = ad[3:0]; b4.b_dig = bd[3:0]; end
      default: begin b8.start = st; b8.sub = sb; b8.in_valid = vl; b8.a_dig = ad; b8.b_dig = bd; end
    endcase
  endtask

  function automatic logic get_busy(input int inst);
    case (inst)
      1:       return b1.busy;
      4:       return b4.busy;
      default: return b8.busy;
    endcase
  endfunction

  function automatic logic [7:0] get_sum(input int inst);
    case (inst)
      1:       return b1.sum;
      4:       return b4.sum;
      default: return b8.sum;
    endcase
  endfunction

  // Called at edge+1; returns at edge+1 in the first idle cycle after done.
  task automatic run_op(input int inst, input logic [7:0] a, input logic [7:0] b, input logic sb,
                        input logic [7:0] es, input logic ec, input logic ev,
                        input int stall_at, input int stall_len, input int abort_after);
    int         beats;
    int         n;
    logic [7:0] mask;
    exp_t       e;
    beats = 8 / inst;
    mask  = 8'((1 << inst) - 1);
    drive(inst, 1'b1, sb, 1'b1, a & mask, b & mask);
    e.sum = es; e.c = ec; e.v = ev;
    e.cyc = cyc + beats + stall_len + 1;
    if (abort_after < 0) begin
      case (inst)
        1:       q1.push_back(e);
        4:       q4.push_back(e);
        default: q8.push_back(e);
      endcase
    end
    for (int i = 0; i < beats; i++) begin
      @(posedge clk); #1;
      if (i == abort_after) begin
        drive(inst, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("partial_sum_before_abort", 32'(get_sum(inst)), 32'h0000_00F0);
        rst = 1'b1;
        #1;
        chk("abort_sum",  32'(b1.sum),       32'h0);
        chk("abort_busy", 32'(b1.busy),      32'h0);
        chk("abort_done", 32'(b1.done),      32'h0);
        chk("abort_cout", 32'(b1.carry_out), 32'h0);
        chk("abort_ovf",  32'(b1.overflow),  32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          drive(inst, k == 0, 1'b0, 1'b0, 8'h00, 8'h00);
          @(posedge clk); #1;
        end
      end
      drive(inst, 1'b0, 1'b0, 1'b1, (a >> (i * inst)) & mask, (b >> (i * inst)) & mask);
    end
    @(posedge clk); #1;
    drive(inst, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    n = 0;
    while (get_busy(inst) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("busy_timeout", 32'(get_busy(inst)), 32'h0);
  endtask

  task automatic mon(input int inst, input logic [7:0] s, input logic c, input logic v);
    exp_t e;
    logic have;
    have = 1'b0;
    case (inst)
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      4:       if (q4.size() > 0) begin e = q4.pop_front(); have = 1'b1; end
      default: if (q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: inst D%0d got done at cycle %0d, expected none", inst, cyc);
    end else begin
      chk($sformatf("sum_d%0d", inst),   32'(s),   32'(e.sum));
      chk($sformatf("cout_d%0d", inst),  32'(c),   32'(e.c));
      chk($sformatf("ovf_d%0d", inst),   32'(v),   32'(e.v));
      chk($sformatf("done_cycle_d%0d", inst), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) if (!rst && b1.done) mon(1, b1.sum, b1.carry_out, b1.overflow);
  always @(negedge clk) if (!rst && b4.done) mon(4, b4.sum, b4.carry_out, b4.overflow);
  always @(negedge clk) if (!rst && b8.done) mon(8, b8.sum, b8.carry_out, b8.overflow);

  initial begin
    exp_t       e;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    int         inst;
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum",  32'(b1.sum),       32'h0);
    chk("reset_busy", 32'(b1.busy),      32'h0);
    chk("reset_done", 32'(b1.done),      32'h0);
    chk("reset_cout", 32'(b4.carry_out), 32'h0);
    chk("reset_ovf",  32'(b8.overflow),  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Bit-serial additions, back to back.
    run_op(1, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, -1, 0, -1);
    run_op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1, 0, -1);
    run_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, 0, -1);

    // Nibble-serial subtractions.
    run_op(4, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, -1, 0, -1);
    run_op(4, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1, 0, -1);

    // Stall for 3 cycles with a stray start; nothing further may start.
    run_op(1, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 3, 3, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_op_busy", 32'(b1.busy), 32'h0);
    chk("held_sum", 32'(b1.sum), 32'h7F);

    // Abort after 4 beats, then a clean operation.
    run_op(1, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, -1, 0, 4);
    run_op(1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1, 0, -1);

    // Single-beat width.
    run_op(8, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, -1, 0, -1);
    run_op(8, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, -1, 0, -1);

    for (int k = 0; k < 1000; k++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rs   = 1'($urandom);
      inst = (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 4 : 8);
      e    = model(ra, rb, rs);
      run_op(inst, ra, rb, rs, e.sum, e.c, e.v, -1, 0, -1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("pending_d1", 32'(q1.size()), 32'h0);
    chk("pending_d4", 32'(q4.size()), 32'h0);
    chk("pending_d8", 32'(q8.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
